// File: rtl/main_fsm.sv
// Multicycle main control FSM: walks each instruction through Fetch/Decode/Execute/Writeback
// and drives every datapath enable, mux select and the 2-bit ALUOp for alu_decoder.
module main_fsm #(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       mem_ready,
   output logic       PCUpdate,
   output logic       Branch,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       illegal_instr,
   output logic       instr_retire,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_AUIPC    = 4'd13
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   state_t state, state_next;
   logic   ready;
   logic   pc_upd, br, reg_wr, mem_wr, ir_wr;

   assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

   // NOTE: state is sequential, so it uses non-blocking assignment and resets asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_next;
   end

   // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_next    = S_FETCH;
      pc_upd        = 1'b0;
      br            = 1'b0;
      reg_wr        = 1'b0;
      mem_wr        = 1'b0;
      ir_wr         = 1'b0;
      AdrSrc        = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ALUOp         = 2'b00;
      illegal_instr = 1'b0;
      instr_retire  = 1'b0;
      unique case (state)
         S_FETCH: begin
            ResultSrc  = 2'b10;
            ALUSrcB    = 2'b10;
            ir_wr      = ready;
            pc_upd     = ready;
            state_next = ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = S_EXECR;
               OP_ITYPE:          state_next = S_EXECI;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               OP_JALR:           state_next = S_JALR;
               OP_LUI:            state_next = S_LUI;
               OP_AUIPC:          state_next = S_AUIPC;
               default: begin
                  illegal_instr = 1'b1;
                  instr_retire  = 1'b1;
                  state_next    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc     = 1'b1;
            state_next = ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc    = 2'b01;
            reg_wr       = 1'b1;
            instr_retire = 1'b1;
         end
         S_MEMWRITE: begin
            // The write strobe stays up through the whole stall; memory samples it with mem_ready.
            AdrSrc       = 1'b1;
            mem_wr       = 1'b1;
            instr_retire = ready;
            state_next   = ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            ALUSrcA    = 2'b10;
            ALUOp      = 2'b10;
            state_next = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUOp      = 2'b10;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            reg_wr       = 1'b1;
            instr_retire = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA      = 2'b10;
            ALUOp        = 2'b01;
            br           = 1'b1;
            instr_retire = 1'b1;
         end
         S_JAL: begin
            // PC takes the target held in ALUOut while the ALU forms OldPC+4 for the link write.
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            pc_upd     = 1'b1;
            state_next = S_ALUWB;
         end
         S_JALR: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            state_next = S_JAL;
         end
         S_LUI: begin
            ALUSrcA    = 2'b11;
            ALUSrcB    = 2'b01;
            state_next = S_ALUWB;
         end
         S_AUIPC: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b01;
            state_next = S_ALUWB;
         end
         default: state_next = S_FETCH;
      endcase
   end

   // Write enables are held low for the whole reset, even though FETCH is the reset state.
   assign PCUpdate = pc_upd & rst_n;
   assign Branch   = br     & rst_n;
   assign RegWrite = reg_wr & rst_n;
   assign MemWrite = mem_wr & rst_n;
   assign IRWrite  = ir_wr  & rst_n;
   assign state_o  = state;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: stimulus queues the expected output word for each cycle,
// a negedge monitor pops and compares it against the DUT.
module tb_main_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = 7'd0;
   logic       mem_ready = 1'b0;
   logic       PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic       illegal_instr, instr_retire;
   logic [3:0] state_o;

   main_fsm #(.MEM_WAIT_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal_instr(illegal_instr),
      .instr_retire(instr_retire), .state_o(state_o)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] R_OP  = 7'b0110011, I_OP   = 7'b0010011, LW_OP  = 7'b0000011;
   localparam logic [6:0] SW_OP = 7'b0100011, BEQ_OP = 7'b1100011, JAL_OP = 7'b1101111;
   localparam logic [6:0] JALR_OP = 7'b1100111, LUI_OP = 7'b0110111, AUIPC_OP = 7'b0010111;
   localparam logic [6:0] BAD_OP  = 7'b1111111;

   typedef struct packed {
      logic [7:0]  idx;
      logic [19:0] v;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail = 0;
   int          seq = 0;
   logic [19:0] got;

   assign got = {PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUOp, illegal_instr, instr_retire, state_o};

   // Output word expected in state s, from the per-state control table.
   function automatic logic [19:0] exp_vec(input logic [3:0] s, input logic rdy,
                                           input logic ill, input logic in_rst);
      logic pcu, br, rw, mw, irw, adr, il, ret;
      logic [1:0] rs, sa, sb, aop;
      {pcu, br, rw, mw, irw, adr, il, ret} = 8'd0;
      {rs, sa, sb, aop} = 8'd0;
      case (s)
         4'd0:  begin rs = 2'b10; sb = 2'b10; irw = rdy; pcu = rdy; end
         4'd1:  begin sa = 2'b01; sb = 2'b01; il = ill; ret = ill; end
         4'd2:  begin sa = 2'b10; sb = 2'b01; end
         4'd3:  begin adr = 1'b1; end
         4'd4:  begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
         4'd5:  begin adr = 1'b1; mw = 1'b1; ret = rdy; end
         4'd6:  begin sa = 2'b10; aop = 2'b10; end
         4'd7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
         4'd8:  begin rw = 1'b1; ret = 1'b1; end
         4'd9:  begin sa = 2'b10; aop = 2'b01; br = 1'b1; ret = 1'b1; end
         4'd10: begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
         4'd11: begin sa = 2'b10; sb = 2'b01; end
         4'd12: begin sa = 2'b11; sb = 2'b01; end
         4'd13: begin sa = 2'b01; sb = 2'b01; end
         default: ;
      endcase
      if (in_rst) {pcu, br, rw, mw, irw} = 5'd0;
      return {pcu, br, rw, mw, irw, adr, rs, sa, sb, aop, il, ret, s};
   endfunction

   task automatic check(input logic [7:0] idx, input logic [19:0] actual, input logic [19:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL cycle%0d outputs got=%05h expected=%05h (state got %0d expected %0d)",
                  idx, actual, expected, actual[3:0], expected[3:0]);
      end
   endtask

   // One clock: drive inputs just after the edge and queue the expected outputs for that cycle.
   task automatic cyc(input logic r, input logic rdy, input logic [6:0] o,
                      input logic [3:0] s, input logic ill);
      @(posedge clk);
      #1;
      rst_n     = r;
      mem_ready = rdy;
      op        = o;
      sb_q.push_back({seq[7:0], exp_vec(s, rdy, ill, !r)});
      seq++;
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         check(mon_e.idx, got, mon_e.v);
      end
   end

   initial begin
      // reset state, enables forced low even with mem_ready high
      cyc(0, 0, R_OP, 4'd0, 0);
      cyc(0, 1, R_OP, 4'd0, 0);
      // fetch stall, then sw into MEMWRITE and reset mid-instruction
      cyc(1, 0, SW_OP, 4'd0, 0);
      cyc(1, 1, SW_OP, 4'd0, 0);
      cyc(1, 1, SW_OP, 4'd1, 0);
      cyc(1, 1, SW_OP, 4'd2, 0);
      cyc(1, 0, SW_OP, 4'd5, 0);
      cyc(0, 0, SW_OP, 4'd0, 0);
      cyc(0, 1, SW_OP, 4'd0, 0);
      // release with mem_ready=1, R-type: 0,1,6,8
      cyc(1, 1, R_OP, 4'd0, 0);
      cyc(1, 1, R_OP, 4'd1, 0);
      cyc(1, 1, R_OP, 4'd6, 0);
      cyc(1, 1, R_OP, 4'd8, 0);
      // lw with three stalled MEMREAD cycles
      cyc(1, 1, LW_OP, 4'd0, 0);
      cyc(1, 1, LW_OP, 4'd1, 0);
      cyc(1, 1, LW_OP, 4'd2, 0);
      for (int i = 0; i < 3; i++) cyc(1, 0, LW_OP, 4'd3, 0);
      cyc(1, 1, LW_OP, 4'd3, 0);
      cyc(1, 1, LW_OP, 4'd4, 0);
      // sw with two stalled MEMWRITE cycles
      cyc(1, 1, SW_OP, 4'd0, 0);
      cyc(1, 1, SW_OP, 4'd1, 0);
      cyc(1, 1, SW_OP, 4'd2, 0);
      cyc(1, 0, SW_OP, 4'd5, 0);
      cyc(1, 0, SW_OP, 4'd5, 0);
      cyc(1, 1, SW_OP, 4'd5, 0);
      // jalr: 0,1,11,10,8 (mem_ready ignored in JALR)
      cyc(1, 1, JALR_OP, 4'd0, 0);
      cyc(1, 1, JALR_OP, 4'd1, 0);
      cyc(1, 0, JALR_OP, 4'd11, 0);
      cyc(1, 1, JALR_OP, 4'd10, 0);
      cyc(1, 1, JALR_OP, 4'd8, 0);
      // illegal opcode retires straight from DECODE
      cyc(1, 1, BAD_OP, 4'd0, 0);
      cyc(1, 1, BAD_OP, 4'd1, 1);
      // I-type with mem_ready low in non-memory states
      cyc(1, 1, I_OP, 4'd0, 0);
      cyc(1, 0, I_OP, 4'd1, 0);
      cyc(1, 0, I_OP, 4'd7, 0);
      cyc(1, 0, I_OP, 4'd8, 0);
      // beq: 3 cycles
      cyc(1, 1, BEQ_OP, 4'd0, 0);
      cyc(1, 1, BEQ_OP, 4'd1, 0);
      cyc(1, 0, BEQ_OP, 4'd9, 0);
      // jal, lui, auipc
      cyc(1, 1, JAL_OP, 4'd0, 0);
      cyc(1, 1, JAL_OP, 4'd1, 0);
      cyc(1, 1, JAL_OP, 4'd10, 0);
      cyc(1, 1, JAL_OP, 4'd8, 0);
      cyc(1, 1, LUI_OP, 4'd0, 0);
      cyc(1, 1, LUI_OP, 4'd1, 0);
      cyc(1, 1, LUI_OP, 4'd12, 0);
      cyc(1, 1, LUI_OP, 4'd8, 0);
      cyc(1, 1, AUIPC_OP, 4'd0, 0);
      cyc(1, 1, AUIPC_OP, 4'd1, 0);
      cyc(1, 1, AUIPC_OP, 4'd13, 0);
      cyc(1, 1, AUIPC_OP, 4'd8, 0);
      cyc(1, 0, R_OP, 4'd0, 0);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expected entries left unchecked, required 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
